// File: rtl/core_muldiv_seq.sv
// core_muldiv_seq: multi-cycle RV32M multiply/divide sequencer for the EX stage.
//
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   start_i    EX holds a valid M-op; held high until done_o is seen
//   funct3_i   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   in1_i      forwarded rs1 value
//   in2_i      forwarded rs2 value
//   flush_i    kill of the op currently in EX
//   stall_o    hold pipeline (combinational)
//   busy_o     sequencer not in IDLE
//   done_o     one-cycle pulse, result_o valid
//   result_o   registered result, held until the next done
//
// Handshake: an op is accepted in IDLE when start_i=1 and flush_i=0. The
// requester keeps start_i and the operands stable until it sees done_o; while
// waiting, stall_o = start_i & ~done_o & ~flush_i holds the pipeline.
//
// Optional build macro MULDIV_FASTPATH_EN: divide-by-zero and signed overflow
// go straight from IDLE to DONE instead of running the full divider.
module core_muldiv_seq #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3;
  logic [XLEN-1:0] op1, op2;
  logic [XLEN-1:0] quo, rem, dvs;

  logic accept;
  assign accept = start_i & ~flush_i;

  // Division special cases that RISC-V defines without trapping.
  function automatic logic is_special(input logic [2:0] f, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic ovf;
    ovf = ~f[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == {XLEN{1'b1}});
    return (b == '0) | ovf;
  endfunction

  function automatic logic [XLEN-1:0] special_res(input logic [2:0] f,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    if (b == '0) return f[1] ? a : {XLEN{1'b1}};
    // signed overflow: quotient is the dividend, remainder is zero
    return f[1] ? '0 : a;
  endfunction

  logic fast_special;
`ifdef MULDIV_FASTPATH_EN
  assign fast_special = funct3_i[2] & is_special(funct3_i, in1_i, in2_i);
`else
  assign fast_special = 1'b0;
`endif

  // Multiply: extend each operand to 2*XLEN per signedness; the truncated
  // 2*XLEN product is exact modulo 2^(2*XLEN).
  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0] mul_res;
  assign a_sgn   = (f3 == 3'd1) | (f3 == 3'd2);
  assign b_sgn   = (f3 == 3'd1);
  assign ext_a   = {{XLEN{a_sgn & op1[XLEN-1]}}, op1};
  assign ext_b   = {{XLEN{b_sgn & op2[XLEN-1]}}, op2};
  assign prod    = ext_a * ext_b;
  assign mul_res = (f3 == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // One restoring step on magnitudes; XLEN+1 bits hold the shifted remainder.
  logic [XLEN:0]   shl_rem, diff;
  logic [XLEN-1:0] quo_nxt, rem_nxt;
  assign shl_rem = {rem, quo[XLEN-1]};
  assign diff    = shl_rem - {1'b0, dvs};
  assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
  assign rem_nxt = diff[XLEN] ? shl_rem[XLEN-1:0] : diff[XLEN-1:0];

  logic            div_sgn, neg_q, neg_r;
  logic [XLEN-1:0] q_fix, r_fix, div_res;
  assign div_sgn = ~f3[0];
  assign neg_q   = div_sgn & (op1[XLEN-1] ^ op2[XLEN-1]);
  assign neg_r   = div_sgn & op1[XLEN-1];
  assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix   = neg_r ? -rem_nxt : rem_nxt;
  assign div_res = is_special(f3, op1, op2) ? special_res(f3, op1, op2)
                 : (f3[1] ? r_fix : q_fix);

  logic            in_sgn;
  assign in_sgn = funct3_i[2] & ~funct3_i[0];

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) begin
        if (!funct3_i[2])     state_nxt = S_MUL;
        else if (fast_special) state_nxt = S_DONE;
        else                  state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush_i)       state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o  = (state != S_IDLE);
    done_o  = (state == S_DONE);
    stall_o = start_i & ~done_o & ~flush_i;
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt      <= '0;
      f3       <= '0;
      op1      <= '0;
      op2      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          f3  <= funct3_i;
          op1 <= in1_i;
          op2 <= in2_i;
          cnt <= funct3_i[2] ? DIV_CNT : MUL_CNT;
          rem <= '0;
          quo <= (in_sgn & in1_i[XLEN-1]) ? -in1_i : in1_i;
          dvs <= (in_sgn & in2_i[XLEN-1]) ? -in2_i : in2_i;
          if (fast_special) result_o <= special_res(funct3_i, in1_i, in2_i);
        end
        S_MUL: if (!flush_i) begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) result_o <= mul_res;
        end
        S_DIV: if (!flush_i) begin
          cnt <= cnt - 1'b1;
          quo <= quo_nxt;
          rem <= rem_nxt;
          if (cnt == '0) result_o <= div_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_muldiv_seq.sv
module tb_core_muldiv_seq;

  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] in1, in2;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef MULDIV_FASTPATH_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  core_muldiv_seq #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .funct3_i(funct3),
    .in1_i(in1), .in2_i(in2), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Drives one op from IDLE (cycle 0) until done_o is seen; reports latency,
  // result and whether stall_o was high before done and low in the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output bit stall_ok);
    start = 1; funct3 = f; in1 = a; in2 = b;
    lat = -1; res = 32'h0; stall_ok = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c; res = result;
        if (stall !== 1'b0) stall_ok = 0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; funct3 = 0; in1 = 0; in2 = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 0 || done !== 0 || result !== 32'h0 || stall !== 0)
      $display("FAIL reset: busy=%b done=%b result=%h stall=%b, want 0 0 00000000 0", busy, done, result, stall);
    else pass_cnt++;
    start = 1;
    #1;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL reset_stall: stall=%b want 1", stall);
    else pass_cnt++;
    @(posedge clk); #1;
    start = 0; rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res; bit sok;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, lat, res, sok);
    total_cnt++;
    if (lat !== 3 || res !== 32'hFFFFFFEB)
      $display("FAIL mul: lat=%0d res=%h want 3 ffffffeb", lat, res);
    else pass_cnt++;
    total_cnt++;
    if (!sok) $display("FAIL mul_stall: stall profile wrong, want high cycles 0-2 low at 3");
    else pass_cnt++;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, sok);
    total_cnt++;
    if (res !== 32'hFFFFFFFE) $display("FAIL mulhu: res=%h want fffffffe", res);
    else pass_cnt++;
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, lat, res, sok);
    total_cnt++;
    if (res !== 32'hFFFFFFFF) $display("FAIL mulhsu: res=%h want ffffffff", res);
    else pass_cnt++;
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, lat, res, sok);
    total_cnt++;
    if (res !== 32'hFFFFFFFF) $display("FAIL mulh: res=%h want ffffffff", res);
    else pass_cnt++;
    run_op(3'd3, 32'hFFFFFFFF, 32'd2, lat, res, sok);
    total_cnt++;
    if (res !== 32'h00000001) $display("FAIL mulhu2: res=%h want 00000001", res);
    else pass_cnt++;
  endtask

  task automatic test_div();
    int lat; logic [31:0] res; bit sok;
    run_op(3'd4, 32'hFFFFFFEC, 32'd3, lat, res, sok);
    total_cnt++;
    if (lat !== 33 || res !== 32'hFFFFFFFA)
      $display("FAIL div: lat=%0d res=%h want 33 fffffffa", lat, res);
    else pass_cnt++;
    total_cnt++;
    if (!sok) $display("FAIL div_stall: stall profile wrong");
    else pass_cnt++;
    run_op(3'd6, 32'hFFFFFFEC, 32'd3, lat, res, sok);
    total_cnt++;
    if (res !== 32'hFFFFFFFE) $display("FAIL rem: res=%h want fffffffe", res);
    else pass_cnt++;
    run_op(3'd7, 32'hFFFFFFFF, 32'd10, lat, res, sok);
    total_cnt++;
    if (res !== 32'd5) $display("FAIL remu: res=%h want 00000005", res);
    else pass_cnt++;
    run_op(3'd4, 32'd20, 32'hFFFFFFF9, lat, res, sok);
    total_cnt++;
    if (res !== 32'hFFFFFFFE) $display("FAIL div_negdivisor: res=%h want fffffffe", res);
    else pass_cnt++;
  endtask

  task automatic test_special();
    int lat; logic [31:0] res; bit sok;
    run_op(3'd5, 32'd5, 32'd0, lat, res, sok);
    total_cnt++;
    if (lat !== SPECIAL_LAT || res !== 32'hFFFFFFFF)
      $display("FAIL divu_by_zero: lat=%0d res=%h want %0d ffffffff", lat, res, SPECIAL_LAT);
    else pass_cnt++;
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, lat, res, sok);
    total_cnt++;
    if (lat !== SPECIAL_LAT || res !== 32'h0)
      $display("FAIL rem_overflow: lat=%0d res=%h want %0d 00000000", lat, res, SPECIAL_LAT);
    else pass_cnt++;
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, lat, res, sok);
    total_cnt++;
    if (res !== 32'h80000000) $display("FAIL div_overflow: res=%h want 80000000", res);
    else pass_cnt++;
    run_op(3'd6, 32'hFFFFFFEC, 32'd0, lat, res, sok);
    total_cnt++;
    if (res !== 32'hFFFFFFEC) $display("FAIL rem_by_zero: res=%h want ffffffec", res);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; bit sok; bit saw_done;
    run_op(3'd0, 32'd5, 32'd5, lat, res, sok);  // result_o = 25
    saw_done = 0;
    start = 1; funct3 = 3'd4; in1 = 32'hFFFFFFEC; in2 = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    flush = 1;  // cycle 10
    @(negedge clk); if (done) saw_done = 1;
    @(posedge clk); #1;
    flush = 0; start = 0;  // cycle 11
    @(negedge clk);
    total_cnt++;
    if (busy !== 0 || done !== 0 || saw_done || result !== 32'd25)
      $display("FAIL flush: busy=%b done=%b saw_done=%b result=%h want 0 0 0 00000019", busy, done, saw_done, result);
    else pass_cnt++;
    @(posedge clk); #1;  // cycle 12
    run_op(3'd0, 32'd2, 32'd3, lat, res, sok);
    total_cnt++;
    if (lat !== 3 || res !== 32'd6)
      $display("FAIL flush_then_mul: lat=%0d res=%h want 3 00000006", lat, res);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 0;
    start = 1; funct3 = 3'd4; in1 = 32'd100; in2 = 32'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    rst_n = 0;  // cycle 5
    @(negedge clk); if (done) saw_done = 1;
    @(posedge clk); #1;
    rst_n = 1; start = 0;  // cycle 6
    @(negedge clk);
    total_cnt++;
    if (busy !== 0 || result !== 32'h0 || done !== 0 || saw_done)
      $display("FAIL reset_mid: busy=%b result=%h done=%b saw_done=%b want 0 00000000 0 0", busy, result, done, saw_done);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; bit sok;
    run_op(3'd0, 32'd9, 32'd9, lat, res, sok);
    total_cnt++;
    if (lat !== 3 || res !== 32'd81) $display("FAIL b2b_mul: lat=%0d res=%h want 3 00000051", lat, res);
    else pass_cnt++;
    run_op(3'd5, 32'd100, 32'd7, lat, res, sok);
    total_cnt++;
    if (lat !== 33 || res !== 32'd14) $display("FAIL b2b_divu: lat=%0d res=%h want 33 0000000e", lat, res);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (result !== 32'd14 || busy !== 0) $display("FAIL result_hold: result=%h busy=%b want 0000000e 0", result, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
